// File: rtl/product_accumulator.sv
// Sums N_TERMS consecutive multiplier products into an AW-bit accumulator.
// Products arrive on a valid/ready handshake. The total leaves on a valid/ready handshake.
module product_accumulator #(
    parameter int PW      = 7,
    parameter int AW      = 10,
    parameter int N_TERMS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] product,
    output logic [AW-1:0] acc_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overflow,
    output logic [7:0]    term_count,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_TERM = 8'(N_TERMS - 1);

    state_t      state;
    state_t      next_state;
    logic        transfer;
    logic [AW:0] sum_ext;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign transfer  = in_ready && in_valid;

    // The extra top bit of the widened add is the carry out of the AW-bit accumulator.
    assign sum_ext = {1'b0, acc_out} + {{(AW + 1 - PW){1'b0}}, product};

    // NOTE: sequential state uses non-blocking assignments.
    // Every register then samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default first.
    // Without it, a path that never assigns next_state would infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = ACCUM;
            ACCUM:   if (transfer && term_count == LAST_TERM) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out    <= '0;
            term_count <= '0;
            overflow   <= 1'b0;
        end else if (state == IDLE && start) begin
            acc_out    <= '0;
            term_count <= '0;
            overflow   <= 1'b0;
        end else if (transfer) begin
            acc_out    <= sum_ext[AW-1:0];
            term_count <= term_count + 8'd1;
            if (sum_ext[AW]) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator.
// It runs a vector table through a scoreboard queue, then hand-written corner sequences.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [6:0] product = '0;
    logic       in_ready, out_valid, overflow, busy;
    logic [9:0] acc_out;
    logic [7:0] term_count;

    // Second instance sized so that overflow can actually occur.
    logic       start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [6:0] product1 = '0;
    logic       in_ready1, out_valid1, overflow1, busy1;
    logic [6:0] acc_out1;
    logic [7:0] term_count1;

    always #5 clk = ~clk;

    product_accumulator #(.PW(7), .AW(10), .N_TERMS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .term_count(term_count), .busy(busy)
    );

    product_accumulator #(.PW(7), .AW(7), .N_TERMS(2)) dut_ovf (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .product(product1), .acc_out(acc_out1), .out_valid(out_valid1), .out_ready(out_ready1),
        .overflow(overflow1), .term_count(term_count1), .busy(busy1)
    );

    typedef struct {
        logic [3:0][6:0] p;
        int              gap;
        int              hold;
        logic [9:0]      acc;
        logic            ovf;
    } vec_t;

    typedef struct {
        logic [9:0] acc;
        logic       ovf;
        logic [7:0] tc;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                           input int gap, input int hold, input int acc, input bit ovf);
        vecs[i].p    = {7'(d), 7'(c), 7'(b), 7'(a)};
        vecs[i].gap  = gap;
        vecs[i].hold = hold;
        vecs[i].acc  = 10'(acc);
        vecs[i].ovf  = ovf;
    endtask

    // Each of these tasks is entered and left on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [6:0] p, input int idx);
        int waited = 0;
        in_valid = 1'b1;
        product  = p;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("term_count_after_%0d", idx), 32'(term_count), 32'(idx + 1));
    endtask

    task automatic collect(input string name, input int hold, input bit ignore_start);
        int   waited = 0;
        exp_t e;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_out_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: queue empty expected 1 entry", name);
            return;
        end
        e = sb.pop_front();
        check({name, "_acc"}, 32'(acc_out), 32'(e.acc));
        check({name, "_ovf"}, 32'(overflow), 32'(e.ovf));
        check({name, "_tc"}, 32'(term_count), 32'(e.tc));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({name, "_hold_acc"}, 32'(acc_out), 32'(e.acc));
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        start     = ignore_start;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({name, "_stay_idle"}, 32'(busy), 32'd0);
        check({name, "_idle_acc_held"}, 32'(acc_out), 32'(e.acc));
    endtask

    // Reference model: unsigned sum modulo 2^10, with a carry flag that sticks.
    function automatic exp_t model(input logic [3:0][6:0] p);
        int   s = 0;
        exp_t r;
        r.ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = s + int'(p[k]);
            if (s >= 1024) begin
                r.ovf = 1'b1;
                s = s - 1024;
            end
        end
        r.acc = 10'(s);
        r.tc  = 8'd4;
        return r;
    endfunction

    initial begin
        exp_t e;
        set_vec(0, 6, 15, 0, 105, 0, 5, 126, 0);
        set_vec(1, 6, 15, 0, 105, 3, 0, 126, 0);
        set_vec(2, 105, 105, 105, 105, 0, 0, 420, 0);
        set_vec(3, 1, 2, 3, 4, 1, 1, 10, 0);
        set_vec(4, 0, 0, 0, 0, 0, 0, 0, 0);

        #12;
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_tc", 32'(term_count), 32'd0);
        check("rst_flags", {29'd0, overflow, out_valid, in_ready}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 5; v++) begin
            e.acc = vecs[v].acc;
            e.ovf = vecs[v].ovf;
            e.tc  = 8'd4;
            sb.push_back(e);
            pulse_start();
            check($sformatf("vec%0d_accum_ready", v), 32'(in_ready), 32'd1);
            check($sformatf("vec%0d_cleared", v), 32'(acc_out), 32'd0);
            for (int i = 0; i < 4; i++) begin
                for (int g = 0; g < vecs[v].gap; g++) @(negedge clk);
                send(vecs[v].p[i], i);
            end
            collect($sformatf("vec%0d", v), vecs[v].hold, 1'b0);
        end

        // start during ACCUM and start together with the output handshake both have no effect
        sb.push_back(model({7'd40, 7'd30, 7'd20, 7'd10}));
        pulse_start();
        send(7'd10, 0);
        send(7'd20, 1);
        pulse_start();
        check("ign_start_tc", 32'(term_count), 32'd2);
        check("ign_start_acc", 32'(acc_out), 32'd30);
        send(7'd30, 2);
        send(7'd40, 3);
        collect("ignore", 0, 1'b1);
        check("ign_no_restart_ready", 32'(in_ready), 32'd0);

        // asynchronous reset after two of the four terms
        pulse_start();
        send(7'd50, 0);
        send(7'd60, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_acc", 32'(acc_out), 32'd0);
        check("midrst_tc", 32'(term_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_stays_idle", 32'(busy), 32'd0);
        sb.push_back(model({7'd1, 7'd1, 7'd1, 7'd1}));
        pulse_start();
        for (int i = 0; i < 4; i++) send(7'd1, i);
        collect("after_rst", 0, 1'b0);

        // overflow on the narrow instance: 105 + 105 = 210, and 210 mod 128 = 82
        start1 = 1'b1;
        @(negedge clk);
        start1    = 1'b0;
        in_valid1 = 1'b1;
        product1  = 7'd105;
        check("ovf_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        check("ovf_first_acc", 32'(acc_out1), 32'd105);
        check("ovf_first_flag", 32'(overflow1), 32'd0);
        @(negedge clk);
        in_valid1 = 1'b0;
        check("ovf_valid", 32'(out_valid1), 32'd1);
        check("ovf_acc", 32'(acc_out1), 32'd82);
        check("ovf_flag", 32'(overflow1), 32'd1);
        check("ovf_tc", 32'(term_count1), 32'd2);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("ovf_idle_flag_held", 32'(overflow1), 32'd1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("ovf_cleared_by_start", 32'(overflow1), 32'd0);
        check("ovf_acc_cleared", 32'(acc_out1), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 3x4-bit combinational multiplier: takes its 7-bit product C6..C0 through a valid/ready handshake.
- Sums a programmed number of consecutive products into a wider accumulator and presents the total with a valid/ready output handshake.
- Intended use: dot-product / multiply-accumulate labs built on the existing multiplier; the multiplier stays combinational and this block supplies all sequencing.

Parameters:
- PW, 7, product input width (matches C6..C0 of the multiplier)
- AW, 10, accumulator width; must be >= PW
- N_TERMS, 4, number of products per accumulation; legal range 1..255

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begins a new accumulation when sampled high in IDLE
- in_valid  input  1  product input is valid
- in_ready  output  1  block accepts product this cycle
- product  input  PW  product from multiplier, bit 0 = C0
- acc_out  output  AW  accumulated sum; meaningful when out_valid=1
- out_valid  output  1  result available
- out_ready  input  1  downstream consumes result
- overflow  output  1  sticky flag: some addition carried out of AW bits in the current accumulation
- term_count  output  8  products accepted so far in current accumulation
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async, immediate, any state, including mid-accumulation or with out_valid high): state=IDLE, acc_out=0, term_count=0, overflow=0, out_valid=0, in_ready=0, busy=0. Partial sums are discarded, no output is produced.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0; out_valid=0.
  - start=1 -> next ACCUM; acc_out cleared to 0, term_count cleared to 0, overflow cleared to 0.
  - start=0 -> stay; outputs hold their last values.
- ACCUM:
  - in_ready=1 (combinational from state only, no dependence on in_valid).
  - A transfer occurs on a rising edge with in_valid=1 and in_ready=1: acc_out <= acc_out + zero-extended product (mod 2^AW); term_count <= term_count+1.
  - If the AW-bit add carries out, overflow <= 1 and stays set until next start or rst.
  - When the transfer makes term_count reach N_TERMS -> next DONE in the same edge. Latency: result is visible with out_valid=1 on the cycle after the last accepted product.
  - in_valid=0 -> no change; there is no timeout.
  - start is ignored in ACCUM.
- DONE:
  - out_valid=1, in_ready=0; acc_out, overflow and term_count are held stable.
  - out_valid=1 and out_ready=1 on an edge -> next IDLE, out_valid low the following cycle. acc_out keeps its value in IDLE until the next start.
  - out_ready=0 -> hold indefinitely (backpressure). start is ignored in DONE.
  - start=1 coincident with the out_ready handshake is also ignored; a new run needs start in IDLE. Minimum gap between runs is therefore one IDLE cycle.
- Products arriving while in_ready=0 are not consumed; upstream must hold them.
- Arithmetic is unsigned throughout. Maximum product is 7x15 = 105; with defaults, 4x105 = 420 < 1024, so overflow never sets at default sizing.
- Outputs are registered except in_ready, out_valid and busy, which decode directly from state.

Test Plan:
- Basic sum: rst pulse, start, then products 6, 15, 0, 105 each with in_valid=1 -> in_ready high 4 cycles; next cycle out_valid=1, acc_out=126, term_count=4, overflow=0.
- Gaps: same four products with in_valid low for 3 cycles between each -> identical result 126; term_count increments only on transfers.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> acc_out stays 126, out_valid stays 1, in_ready stays 0; raise out_ready -> IDLE next cycle, out_valid=0.
- Overflow: AW=7, N_TERMS=2, products 105 and 105 -> acc_out=210 mod 128 = 82, overflow=1. A following start clears overflow to 0.
- Reset mid-operation: assert rst asynchronously (between clock edges) after 2 of 4 terms -> all outputs 0 and state IDLE immediately. Next start+4 products of 1 gives acc_out=4.
- Ignored controls: pulse start during ACCUM and during DONE with out_ready=1 -> no restart. Sum unaffected; block returns to IDLE and waits for a new start.
